// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - opcodes, FSM states and width helpers for the sequential FP ALU
package fp_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_MUL  = 4'd1;
  localparam logic [3:0] OP_DIV  = 4'd2;
  localparam logic [3:0] OP_SQRT = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_ABS  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_CEQ  = 4'd8;
  localparam logic [3:0] OP_CLT  = 4'd9;
  localparam logic [3:0] OP_CLE  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Mantissa field width for an IEEE-style layout of sign / exponent / mantissa.
  function automatic int man_w(input int width, input int exp_w);
    return width - 1 - exp_w;
  endfunction

  function automatic int max4(input int p, input int q, input int r, input int s);
    int m;
    m = p;
    if (q > m) m = q;
    if (r > m) m = r;
    if (s > m) m = s;
    return m;
  endfunction

  // Counter holds LAT-1 at most, so clog2 of the largest latency suffices (never below 1 bit).
  function automatic int cnt_w(input int lat_max);
    return (lat_max <= 2) ? 1 : $clog2(lat_max);
  endfunction

endpackage

// File: rtl/fp_cmp.sv
// rtl/fp_cmp.sv - combinational FP compare (EQ/LT/LE) with NaN and signed-zero handling
module fp_cmp
  import fp_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             le
);

  localparam int MAN_W = man_w(WIDTH, EXP_W);

  logic             sign_a, sign_b;
  logic [WIDTH-2:0] mag_a, mag_b;
  logic             nan_a, nan_b, any_nan, both_zero;

  assign sign_a    = a[WIDTH-1];
  assign sign_b    = b[WIDTH-1];
  assign mag_a     = a[WIDTH-2:0];
  assign mag_b     = b[WIDTH-2:0];
  assign nan_a     = (&a[WIDTH-2 -: EXP_W]) && (|a[MAN_W-1:0]);
  assign nan_b     = (&b[WIDTH-2 -: EXP_W]) && (|b[MAN_W-1:0]);
  assign any_nan   = nan_a || nan_b;
  assign both_zero = (~|mag_a) && (~|mag_b);

  // Signed-magnitude ordering; any NaN makes every relation false.
  always_comb begin
    eq = 1'b0;
    lt = 1'b0;
    if (!any_nan) begin
      eq = (a == b) || both_zero;
      if (sign_a != sign_b) lt = sign_a && !both_zero;
      else if (!sign_a)     lt = mag_a < mag_b;
      else                  lt = mag_a > mag_b;
    end
    le = lt || eq;
  end

endmodule

// File: rtl/fp_alu_seq.sv
// rtl/fp_alu_seq.sv - handshaked FP ALU: operand latch, per-op latency counter, result hold
module fp_alu_seq
  import fp_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int EXP_W    = 8,
  parameter int OP_W     = 4,
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 16,
  parameter int SQRT_LAT = 20
) (
  input  logic             cpu_clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic [WIDTH-1:0] add_res,
  input  logic [WIDTH-1:0] mul_res,
  input  logic [WIDTH-1:0] div_res,
  input  logic [WIDTH-1:0] sqrt_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cond,
  output logic             invalid_op
);

  localparam int LAT_MAX = max4(ADD_LAT, MUL_LAT, DIV_LAT, SQRT_LAT);
  localparam int CNT_W   = cnt_w(LAT_MAX);

  state_t           state, state_nxt;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture;
  logic             cmp_eq, cmp_lt, cmp_le;
  logic [WIDTH-1:0] res_nxt;
  logic             cond_nxt, inv_nxt;

  // Cycles spent in EXEC minus one; in-block ops finish on the first EXEC edge.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_W-1:0] o);
    case (o)
      OP_ADD, OP_SUB: return CNT_W'(ADD_LAT - 1);
      OP_MUL:         return CNT_W'(MUL_LAT - 1);
      OP_DIV:         return CNT_W'(DIV_LAT - 1);
      OP_SQRT:        return CNT_W'(SQRT_LAT - 1);
      default:        return '0;
    endcase
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = (state == ST_IDLE) && in_valid;
  assign capture   = (state == ST_EXEC) && (cnt == '0);

  fp_cmp #(.WIDTH(WIDTH), .EXP_W(EXP_W)) u_cmp (
    .a  (unit_a),
    .b  (unit_b),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .le (cmp_le)
  );

  // State register.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept -> count down -> hold until consumer takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)    state_nxt = ST_EXEC;
      ST_EXEC: if (cnt == '0)   state_nxt = ST_DONE;
      ST_DONE: if (out_ready)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Result select from the latched opcode; compares return cond in bit 0.
  always_comb begin
    res_nxt  = '0;
    cond_nxt = 1'b0;
    inv_nxt  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: res_nxt = add_res;
      OP_MUL:         res_nxt = mul_res;
      OP_DIV:         res_nxt = div_res;
      OP_SQRT:        res_nxt = sqrt_res;
      OP_ABS:         res_nxt = {1'b0, unit_a[WIDTH-2:0]};
      OP_NEG:         res_nxt = {~unit_a[WIDTH-1], unit_a[WIDTH-2:0]};
      OP_MOV:         res_nxt = unit_a;
      OP_CEQ: begin cond_nxt = cmp_eq; res_nxt = {{(WIDTH-1){1'b0}}, cmp_eq}; end
      OP_CLT: begin cond_nxt = cmp_lt; res_nxt = {{(WIDTH-1){1'b0}}, cmp_lt}; end
      OP_CLE: begin cond_nxt = cmp_le; res_nxt = {{(WIDTH-1){1'b0}}, cmp_le}; end
      default:        inv_nxt = 1'b1;
    endcase
  end

  // Operand latch, latency counter and result capture.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      cnt        <= '0;
      out        <= '0;
      cond       <= 1'b0;
      invalid_op <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op;
        unit_a <= a;
        unit_b <= (op == OP_SUB) ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
        cnt    <= lat_m1(op);
      end else if ((state == ST_EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        out        <= res_nxt;
        cond       <= cond_nxt;
        invalid_op <= inv_nxt;
      end
    end
  end

endmodule
